// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU data-port bridge.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        LATCH,
        RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] DEFAULT_RAM_BASE = 32'h0001_0000;
    localparam logic [31:0] DEFAULT_LED_ADDR = 32'h8000_0000;

    // Halves need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store replication / write enables and
// load byte/half selection with sign or zero extension.
module lsu_lane_align
    import bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] lane_wdata_o,
    output logic [3:0]  lane_wen_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        lane_wdata_o = st_data_i;
        lane_wen_o   = 4'b0000;
        ld_data_o    = ld_word_i;
        ld_byte      = ld_word_i[{addr_lo_i, 3'b000} +: 8];
        ld_half      = ld_word_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: begin
                lane_wdata_o = {4{st_data_i[7:0]}};
                lane_wen_o   = 4'b0001 << addr_lo_i;
                ld_data_o    = {{24{ld_byte[7] & ~is_unsigned_i}}, ld_byte};
            end
            SZ_HALF: begin
                lane_wdata_o = {2{st_data_i[15:0]}};
                lane_wen_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                ld_data_o    = {{16{ld_half[15] & ~is_unsigned_i}}, ld_half};
            end
            SZ_WORD: begin
                lane_wen_o = 4'b1111;
            end
            default: begin
                lane_wen_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_bus_bridge.sv
// Load/store bridge from the CPU data port to a byte-enabled synchronous RAM
// with one LED MMIO register; one outstanding request at a time.
module data_bus_bridge
    import bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] RAM_BASE  = DEFAULT_RAM_BASE,
    parameter logic [31:0] LED_ADDR  = DEFAULT_LED_ADDR,
    parameter int unsigned LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [3:0]           ram_wen,
    output logic [21:0]          ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata,
    output logic [LED_WIDTH-1:0] leds
);

    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic [1:0]           lo_q, lo_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 led_q, led_d;
    logic [21:0]          ram_addr_q, ram_addr_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic                 resp_err_q, resp_err_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;

    logic [31:0] req_off;
    logic        req_in_ram;
    logic        req_is_led;
    logic        req_err;
    logic [31:0] leds_ext;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wen;
    logic [31:0] ld_data;
    logic        ram_store;

    assign req_off    = req_addr - RAM_BASE;
    assign req_in_ram = (req_addr >= RAM_BASE) && ({1'b0, req_off} < RAM_BYTES);
    assign req_is_led = (req_addr == LED_ADDR);
    assign req_err    = (req_size == 2'b11) ||
                        is_misaligned(req_size, req_addr[1:0]) ||
                        !(req_in_ram || req_is_led) ||
                        (req_is_led && (req_size != SZ_WORD));

    always_comb begin
        leds_ext                = '0;
        leds_ext[LED_WIDTH-1:0] = leds_q;
    end

    lsu_lane_align u_lane (
        .size_i        (size_q),
        .is_unsigned_i (uns_q),
        .addr_lo_i     (lo_q),
        .st_data_i     (wdata_q),
        .ld_word_i     (ram_rdata),
        .lane_wdata_o  (lane_wdata),
        .lane_wen_o    (lane_wen),
        .ld_data_o     (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lo_d         = lo_q;
        wdata_d      = wdata_q;
        led_d        = led_q;
        ram_addr_d   = ram_addr_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        leds_d       = leds_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    size_d       = req_size;
                    uns_d        = req_unsigned;
                    lo_d         = req_addr[1:0];
                    wdata_d      = req_wdata;
                    led_d        = req_is_led;
                    ram_addr_d   = req_off[23:2];
                    resp_rdata_d = '0;
                    resp_err_d   = req_err;
                    state_d      = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (led_q) begin
                    if (we_q) begin
                        leds_d = wdata_q[LED_WIDTH-1:0];
                    end else begin
                        resp_rdata_d = leds_ext;
                    end
                    state_d = RESP;
                end else begin
                    state_d = we_q ? RESP : LATCH;
                end
            end
            LATCH: begin
                resp_rdata_d = ld_data;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            lo_q         <= 2'b00;
            wdata_q      <= '0;
            led_q        <= 1'b0;
            ram_addr_q   <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            leds_q       <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lo_q         <= lo_d;
            wdata_q      <= wdata_d;
            led_q        <= led_d;
            ram_addr_q   <= ram_addr_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            leds_q       <= leds_d;
        end
    end

    // Write strobes are decoded from state so a reset in ACCESS kills them at once.
    assign ram_store  = (state_q == ACCESS) && we_q && !led_q;
    assign ram_wen    = ram_store ? lane_wen : 4'b0000;
    assign ram_wdata  = ram_store ? lane_wdata : 32'd0;
    assign ram_addr   = ram_addr_q;
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign leds       = leds_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Self-checking bench: directed vector table, reset-abort sequence and
// randomized traffic against a byte-addressed reference model.
module tb_data_bus_bridge;

    localparam logic [31:0] T_RAM_BASE = 32'h0001_0000;
    localparam logic [31:0] T_LED_ADDR = 32'h8000_0000;
    localparam int          T_WORDS    = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  ram_wen;
    logic [21:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [7:0]  leds;

    int n_cmp  = 0;
    int n_fail = 0;

    data_bus_bridge #(
        .RAM_WORDS (T_WORDS),
        .RAM_BASE  (T_RAM_BASE),
        .LED_ADDR  (T_LED_ADDR),
        .LED_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_wen      (ram_wen),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .leds         (leds)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM with byte enables and one-cycle read latency.
    logic [31:0] ram_mem [0:T_WORDS-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) ram_mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= ram_mem[ram_addr[7:0]];
    end

    // Reference model: flat byte memory plus LED value.
    logic [7:0]  m_mem [0:4*T_WORDS-1];
    logic [31:0] m_leds;

    task automatic model_txn(
        input  logic we, input logic [1:0] sz, input logic uns,
        input  logic [31:0] addr, input logic [31:0] wd,
        output logic err, output logic [31:0] rd, output int lat,
        output logic [3:0] wen, output logic [31:0] wdl, output logic [21:0] wa,
        output logic is_ram);
        int     nb;
        longint off;
        longint val;
        logic   led_hit;
        nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off     = longint'(addr) - longint'(T_RAM_BASE);
        is_ram  = (off >= 0) && (off < 4 * T_WORDS);
        led_hit = (addr == T_LED_ADDR);
        err     = (sz == 2'd3) || ((addr % 32'(nb)) != 0) || (!is_ram && !led_hit) ||
                  (led_hit && sz != 2'd2);
        rd  = '0;
        wen = '0;
        wdl = '0;
        wa  = off[23:2];
        if (err) begin
            lat    = 1;
            is_ram = 1'b0;
        end else if (led_hit) begin
            lat = 2;
            if (we) m_leds = wd & 32'hFF;
            else    rd = m_leds;
        end else if (we) begin
            lat = 2;
            for (int i = 0; i < nb; i++) begin
                m_mem[int'(off) + i] = wd[8*i +: 8];
                wen[(int'(off) + i) % 4] = 1'b1;
            end
            for (int j = 0; j < 4; j++) wdl[8*j +: 8] = wd[8*(j % nb) +: 8];
        end else begin
            lat = 3;
            val = 0;
            for (int i = 0; i < nb; i++) val += longint'(m_mem[int'(off) + i]) << (8 * i);
            if (!uns && nb < 4 && val >= (64'sd1 << (8 * nb - 1))) val -= (64'sd1 << (8 * nb));
            rd = val[31:0];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one request from IDLE (called at a negedge) through its response handshake.
    task automatic exec_check(
        input string tag, input logic we, input logic [1:0] sz, input logic uns,
        input logic [31:0] addr, input logic [31:0] wd, input int hold,
        input logic e_err, input logic [31:0] e_rd, input int e_lat,
        input logic [3:0] e_wen, input logic [31:0] e_wd, input logic [21:0] e_ra,
        input logic e_ram, input logic [31:0] e_leds);
        logic [31:0] rd, wd1;
        logic        err, stable;
        logic [3:0]  wen1, wen_late;
        logic [21:0] ad1;
        int          k, lat;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        wen1 = ram_wen; wd1 = ram_wdata; ad1 = ram_addr; wen_late = '0; k = 1;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
            wen_late |= ram_wen;
        end
        lat = resp_valid ? k : -1;
        if (!resp_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL %s.timeout: resp_valid=0 after %0d cycles, required 1", tag, k);
        end
        rd = resp_rdata; err = resp_err; stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rd || resp_err !== err || req_ready) stable = 1'b0;
            wen_late |= ram_wen;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        $display("txn %s we=%0d sz=%0d uns=%0d addr=%h wd=%h -> rdata=%h err=%0d lat=%0d leds=%h",
                 tag, we, sz, uns, addr, wd, rd, err, lat, leds);
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".rdata"}, rd, e_rd);
        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".wen_access"}, 32'(wen1), 32'(e_wen));
        chk({tag, ".wen_other"}, 32'(wen_late), 32'd0);
        chk({tag, ".leds"}, 32'(leds), e_leds);
        if (e_ram) chk({tag, ".ram_addr"}, 32'(ad1), 32'(e_ra));
        if (e_ram && we) chk({tag, ".ram_wdata"}, wd1, e_wd);
        if (hold > 0) chk({tag, ".hold_stable"}, 32'(stable), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        int          hold;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        logic [3:0]  e_wen;
        logic [31:0] e_wd;
        logic [21:0] e_ra;
        logic        e_ram;
        logic [31:0] e_leds;
    } vec_t;

    function automatic vec_t mkv(
        input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
        input logic [31:0] wd, input int hold, input logic e_err, input logic [31:0] e_rd,
        input int e_lat, input logic [3:0] e_wen, input logic [31:0] e_wd,
        input logic [21:0] e_ra, input logic e_ram, input logic [31:0] e_leds);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.hold = hold;
        v.e_err = e_err; v.e_rd = e_rd; v.e_lat = e_lat; v.e_wen = e_wen; v.e_wd = e_wd;
        v.e_ra = e_ra; v.e_ram = e_ram; v.e_leds = e_leds;
        return v;
    endfunction

    initial begin
        vec_t        vecs [18];
        logic        m_err, m_ram;
        logic [31:0] m_rd, m_wdl;
        int          m_lat;
        logic [3:0]  m_wen;
        logic [21:0] m_wa;
        logic        r_we, r_uns;
        logic [1:0]  r_sz;
        logic [31:0] r_addr, r_wd;
        int          sel;

        for (int i = 0; i < T_WORDS; i++) ram_mem[i] = '0;
        for (int i = 0; i < 4 * T_WORDS; i++) m_mem[i] = '0;
        m_leds = '0;

        // Reset values, checked while reset is asserted.
        #1 rst = 1'b1;
        #2;
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.resp_valid", 32'(resp_valid), 32'd0);
        chk("reset.resp_rdata", resp_rdata, 32'd0);
        chk("reset.resp_err", 32'(resp_err), 32'd0);
        chk("reset.ram_wen", 32'(ram_wen), 32'd0);
        chk("reset.ram_addr", 32'(ram_addr), 32'd0);
        chk("reset.ram_wdata", ram_wdata, 32'd0);
        chk("reset.leds", 32'(leds), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        //             we  sz    uns addr          wdata         hold err rdata         lat wen      wdata         ra      ram leds
        vecs[0]  = mkv(1, 2'd2, 0, 32'h0001_0004, 32'hDEADBEEF, 0, 0, 32'h0,         2, 4'b1111, 32'hDEADBEEF, 22'd1,   1, 32'h00);
        vecs[1]  = mkv(0, 2'd2, 0, 32'h0001_0004, 32'h0,        5, 0, 32'hDEADBEEF,  3, 4'b0000, 32'h0,        22'd1,   1, 32'h00);
        vecs[2]  = mkv(1, 2'd0, 0, 32'h0001_0006, 32'h0000_0080, 0, 0, 32'h0,        2, 4'b0100, 32'h80808080, 22'd1,   1, 32'h00);
        vecs[3]  = mkv(0, 2'd0, 0, 32'h0001_0006, 32'h0,        0, 0, 32'hFFFFFF80,  3, 4'b0000, 32'h0,        22'd1,   1, 32'h00);
        vecs[4]  = mkv(0, 2'd0, 1, 32'h0001_0006, 32'h0,        0, 0, 32'h00000080,  3, 4'b0000, 32'h0,        22'd1,   1, 32'h00);
        vecs[5]  = mkv(0, 2'd1, 0, 32'h0001_0006, 32'h0,        0, 0, 32'hFFFFDE80,  3, 4'b0000, 32'h0,        22'd1,   1, 32'h00);
        vecs[6]  = mkv(0, 2'd1, 1, 32'h0001_0004, 32'h0,        0, 0, 32'h0000BEEF,  3, 4'b0000, 32'h0,        22'd1,   1, 32'h00);
        vecs[7]  = mkv(1, 2'd1, 0, 32'h0001_0002, 32'h0000_1234, 0, 0, 32'h0,        2, 4'b1100, 32'h12341234, 22'd0,   1, 32'h00);
        vecs[8]  = mkv(0, 2'd2, 0, 32'h0001_0000, 32'h0,        0, 0, 32'h12340000,  3, 4'b0000, 32'h0,        22'd0,   1, 32'h00);
        vecs[9]  = mkv(0, 2'd1, 0, 32'h0001_0003, 32'h0,        0, 1, 32'h0,         1, 4'b0000, 32'h0,        22'd0,   0, 32'h00);
        vecs[10] = mkv(0, 2'd2, 0, 32'h0000_0000, 32'h0,        0, 1, 32'h0,         1, 4'b0000, 32'h0,        22'd0,   0, 32'h00);
        vecs[11] = mkv(0, 2'd3, 0, 32'h0001_0000, 32'h0,        0, 1, 32'h0,         1, 4'b0000, 32'h0,        22'd0,   0, 32'h00);
        vecs[12] = mkv(1, 2'd2, 0, 32'h0001_03FC, 32'h12345678, 0, 0, 32'h0,         2, 4'b1111, 32'h12345678, 22'hFF,  1, 32'h00);
        vecs[13] = mkv(0, 2'd2, 0, 32'h0001_0400, 32'h0,        0, 1, 32'h0,         1, 4'b0000, 32'h0,        22'd0,   0, 32'h00);
        vecs[14] = mkv(0, 2'd2, 0, 32'h0001_03FC, 32'h0,        2, 0, 32'h12345678,  3, 4'b0000, 32'h0,        22'hFF,  1, 32'h00);
        vecs[15] = mkv(1, 2'd2, 0, 32'h8000_0000, 32'h0000_00A5, 0, 0, 32'h0,        2, 4'b0000, 32'h0,        22'd0,   0, 32'hA5);
        vecs[16] = mkv(0, 2'd2, 0, 32'h8000_0000, 32'h0,        0, 0, 32'h000000A5,  2, 4'b0000, 32'h0,        22'd0,   0, 32'hA5);
        vecs[17] = mkv(1, 2'd0, 0, 32'h8000_0000, 32'h0000_00FF, 0, 1, 32'h0,        1, 4'b0000, 32'h0,        22'd0,   0, 32'hA5);

        for (int i = 0; i < 18; i++) begin
            model_txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                      m_err, m_rd, m_lat, m_wen, m_wdl, m_wa, m_ram);
            exec_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].uns,
                       vecs[i].addr, vecs[i].wd, vecs[i].hold, vecs[i].e_err, vecs[i].e_rd,
                       vecs[i].e_lat, vecs[i].e_wen, vecs[i].e_wd, vecs[i].e_ra,
                       vecs[i].e_ram, vecs[i].e_leds);
        end

        // Reset while a word store sits in ACCESS: write must vanish, no response.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0001_0004; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort.wen_before", 32'(ram_wen), 32'hF);
        #1 rst = 1'b1;
        #1;
        chk("abort.wen_dropped", 32'(ram_wen), 32'd0);
        chk("abort.req_ready", 32'(req_ready), 32'd1);
        chk("abort.leds", 32'(leds), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_leds = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort.no_resp%0d", c), 32'(resp_valid), 32'd0);
        end
        model_txn(1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0, m_err, m_rd, m_lat, m_wen, m_wdl, m_wa, m_ram);
        exec_check("abort_readback", 1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0, 0,
                   m_err, m_rd, m_lat, m_wen, m_wdl, m_wa, m_ram, m_leds);
        chk("abort_readback.unchanged", m_rd, 32'hDE80BEEF);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            sel   = $urandom_range(0, 9);
            r_we  = 1'($urandom);
            r_uns = 1'($urandom);
            r_sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_wd  = $urandom;
            if (sel <= 6) begin
                r_addr = T_RAM_BASE + 32'($urandom_range(0, 4 * T_WORDS - 1));
                if ($urandom_range(0, 9) < 7) begin
                    if (r_sz == 2'd1) r_addr[0] = 1'b0;
                    else if (r_sz == 2'd2) r_addr[1:0] = 2'b00;
                end
            end else if (sel == 7) begin
                r_addr = T_LED_ADDR;
                if ($urandom_range(0, 3) != 0) r_sz = 2'd2;
            end else if (sel == 8) begin
                r_addr = T_LED_ADDR + 32'($urandom_range(1, 3));
            end else begin
                r_addr = $urandom;
            end
            model_txn(r_we, r_sz, r_uns, r_addr, r_wd, m_err, m_rd, m_lat, m_wen, m_wdl, m_wa, m_ram);
            exec_check($sformatf("rnd%0d", n), r_we, r_sz, r_uns, r_addr, r_wd,
                       $urandom_range(0, 3), m_err, m_rd, m_lat, m_wen, m_wdl, m_wa,
                       m_ram, m_leds);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
